// File: rtl/cache_responder_pkg.sv
// Shared types and default sizes for the per-core cache responder.
package cache_responder_pkg;
  localparam int CACHE_ADDR_W = 12;
  localparam int CACHE_DATA_W = 8;
  localparam int CACHE_LINES  = 16;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, DONE} cache_state_t;
endpackage

// File: rtl/cache_responder_if.sv
// Core request/response bus plus the memory-arbiter port of one cache responder.
interface cache_responder_if #(
  parameter int ADDR_W = cache_responder_pkg::CACHE_ADDR_W,
  parameter int DATA_W = cache_responder_pkg::CACHE_DATA_W
);
  logic              valid_load;
  logic              valid_store;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              hit;
  logic              gnt;
  logic [DATA_W-1:0] rdata;
  logic              protocol_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // slave = the cache; master = the core/memory environment around it
  modport slave (
    input  valid_load, valid_store, address, wdata, mem_rdata, mem_ack,
    output hit, gnt, rdata, protocol_err, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output valid_load, valid_store, address, wdata, mem_rdata, mem_ack,
    input  hit, gnt, rdata, protocol_err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_responder_line_array.sv
// Line storage: valid/dirty/tag/data, combinational read by index, one write port.
module cache_line_array #(
  parameter int LINES   = 16,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 8,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_dirty
);
  logic [LINES-1:0]             valid_q;
  logic [LINES-1:0]             dirty_q;
  logic [LINES-1:0][TAG_W-1:0]  tag_q;
  logic [LINES-1:0][DATA_W-1:0] data_q;

  // Only valid/dirty are cleared; stale tag/data behind a clear bit is never used.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];
endmodule

// File: rtl/cache_responder.sv
// Direct-mapped write-back/write-allocate cache of 1-byte lines between a core and memory.
module cache_responder
  import cache_responder_pkg::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W,
  parameter int LINES  = CACHE_LINES
) (
  input logic              clk,
  input logic              rst,
  cache_responder_if.slave bus
);
  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = ADDR_W - INDEX_W;

  cache_state_t        state, state_nx;
  logic                lat_load;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  logic                req, idle, miss, store_hit;
  logic [INDEX_W-1:0]  req_index, lat_index, rd_index, wr_index;
  logic [TAG_W-1:0]    req_tag, lat_tag, rd_tag, wr_tag;
  logic [DATA_W-1:0]   rd_data, wr_data;
  logic                rd_valid, rd_dirty, we, wr_dirty;

  assign req       = bus.valid_load | bus.valid_store;
  assign idle      = (state == IDLE);
  assign req_index = bus.address[INDEX_W-1:0];
  assign req_tag   = bus.address[ADDR_W-1:INDEX_W];
  assign lat_index = lat_addr[INDEX_W-1:0];
  assign lat_tag   = lat_addr[ADDR_W-1:INDEX_W];
  // Outside IDLE the array is read at the latched line, so the victim is visible in WRITEBACK.
  assign rd_index  = idle ? req_index : lat_index;

  assign bus.hit   = idle & req & rd_valid & (rd_tag == req_tag);
  assign miss      = idle & req & ~bus.hit;
  // Load wins when both strobes arrive together, so the store half never writes.
  assign store_hit = bus.hit & bus.valid_store & ~bus.valid_load;

  cache_line_array #(
    .LINES(LINES), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) u_lines (
    .clk(clk), .rst(rst),
    .rd_index(rd_index), .rd_valid(rd_valid), .rd_dirty(rd_dirty),
    .rd_tag(rd_tag), .rd_data(rd_data),
    .we(we), .wr_index(wr_index), .wr_tag(wr_tag), .wr_data(wr_data), .wr_dirty(wr_dirty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    we       = 1'b0;
    wr_index = lat_index;
    wr_tag   = lat_tag;
    wr_data  = lat_wdata;
    wr_dirty = 1'b1;
    case (state)
      IDLE: begin
        if (store_hit) begin
          we       = 1'b1;
          wr_index = req_index;
          wr_tag   = req_tag;
          wr_data  = bus.wdata;
        end else if (miss) begin
          if (rd_valid && rd_dirty) state_nx = WRITEBACK;
          else                      state_nx = bus.valid_load ? FETCH : DONE;
        end
      end
      WRITEBACK: if (bus.mem_ack) state_nx = lat_load ? FETCH : DONE;
      FETCH: begin
        if (bus.mem_ack) begin
          state_nx = DONE;
          we       = 1'b1;
          wr_data  = bus.mem_rdata;
          wr_dirty = 1'b0;
        end
      end
      DONE: begin
        state_nx = IDLE;
        we       = ~lat_load;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory port is a pure function of state and latched request, so it is stable while mem_req=1.
  assign bus.mem_req   = (state == WRITEBACK) | (state == FETCH);
  assign bus.mem_we    = (state == WRITEBACK);
  assign bus.mem_addr  = (state == WRITEBACK) ? {rd_tag, lat_index} :
                         (state == FETCH)     ? lat_addr : '0;
  assign bus.mem_wdata = (state == WRITEBACK) ? rd_data : '0;
  assign bus.gnt       = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_load         <= 1'b0;
      lat_addr         <= '0;
      lat_wdata        <= '0;
      bus.rdata        <= '0;
      bus.protocol_err <= 1'b0;
    end else begin
      bus.protocol_err <= req & (~idle | (bus.valid_load & bus.valid_store));
      if (miss) begin
        lat_load  <= bus.valid_load;
        lat_addr  <= bus.address;
        lat_wdata <= bus.wdata;
      end
      if (bus.hit && bus.valid_load)          bus.rdata <= rd_data;
      else if (state == FETCH && bus.mem_ack) bus.rdata <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_cache_responder.sv
// Directed scoreboard bench for cache_responder: stimulus pushes expectations, a negedge monitor pops them.
module tb_cache_responder;
  import cache_responder_pkg::*;

  typedef struct { logic we; logic [11:0] addr; logic [7:0] wdata; } mem_exp_t;
  typedef struct { logic load; logic [7:0] data; } gnt_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_responder_if bus();
  cache_responder dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic       q_hit[$];
  logic [7:0] q_rd[$];
  mem_exp_t   q_mem[$];
  gnt_exp_t   q_gnt[$];
  int         n_err_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected or missing event at %0t", name, $time);
  endtask

  // ---------------- monitor ----------------
  logic       rd_pending = 1'b0;
  logic       prev_req = 1'b0, prev_ack = 1'b0;
  logic [11:0] prev_addr = '0;
  logic       e_hit;
  mem_exp_t   m;
  gnt_exp_t   g;

  always @(negedge clk) begin
    if (rst) begin
      rd_pending = 1'b0;
      prev_req   = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (rd_pending) begin
        rd_pending = 1'b0;
        if (q_rd.size() == 0) unexp("hit_rdata");
        else chk("hit_rdata", bus.rdata, q_rd.pop_front());
      end
      if (bus.valid_load | bus.valid_store) begin
        if (q_hit.size() == 0) unexp("req");
        else begin
          e_hit = q_hit.pop_front();
          chk("hit", bus.hit, e_hit);
          if (e_hit && bus.valid_load) rd_pending = 1'b1;
        end
      end else if (bus.hit) unexp("hit_no_req");
      if (bus.mem_req && (!prev_req || prev_ack)) begin
        if (q_mem.size() == 0) unexp("mem_req");
        else begin
          m = q_mem.pop_front();
          chk("mem_we", bus.mem_we, m.we);
          chk("mem_addr", bus.mem_addr, m.addr);
          if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
        end
      end else if (bus.mem_req) chk("mem_addr_stable", bus.mem_addr, prev_addr);
      prev_req  = bus.mem_req;
      prev_ack  = bus.mem_ack;
      prev_addr = bus.mem_addr;
      if (bus.gnt) begin
        if (q_gnt.size() == 0) unexp("gnt");
        else begin
          g = q_gnt.pop_front();
          if (g.load) chk("gnt_rdata", bus.rdata, g.data);
          else        chk("gnt_store", bus.gnt, 1'b1);
        end
      end
      if (bus.protocol_err) begin
        if (n_err_exp == 0) unexp("protocol_err");
        else begin
          n_err_exp--;
          total++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [11:0] a, input logic [7:0] d);
    bus.valid_load  = ld;
    bus.valid_store = st;
    bus.address     = a;
    bus.wdata       = d;
    tick();
    bus.valid_load  = 1'b0;
    bus.valid_store = 1'b0;
  endtask

  task automatic mem_respond(input int dly, input logic [7:0] d);
    int i = 0;
    while (!bus.mem_req && i < 20) begin
      tick();
      i++;
    end
    if (!bus.mem_req) begin
      unexp("mem_req_timeout");
      return;
    end
    repeat (dly - 1) tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = d;
    tick();
    bus.mem_ack   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.valid_load = 1'b0; bus.valid_store = 1'b0;
    bus.address = '0; bus.wdata = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    repeat (2) tick();
    chk("rst_hit", bus.hit, 1'b0);
    chk("rst_gnt", bus.gnt, 1'b0);
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_err", bus.protocol_err, 1'b0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 12'h000);
    chk("rst_mem_wdata", bus.mem_wdata, 8'h00);
    rst = 1'b0;
    tick();

    // cold load miss, fetch returns 0xA5
    q_hit.push_back(1'b0);
    q_mem.push_back('{we: 1'b0, addr: 12'h123, wdata: 8'h00});
    q_gnt.push_back('{load: 1'b1, data: 8'hA5});
    issue(1'b1, 1'b0, 12'h123, 8'h00);
    mem_respond(2, 8'hA5);
    tick();

    // load hit
    q_hit.push_back(1'b1); q_rd.push_back(8'hA5);
    issue(1'b1, 1'b0, 12'h123, 8'h00);
    tick();

    // store hit then load hit sees new data
    q_hit.push_back(1'b1);
    issue(1'b0, 1'b1, 12'h123, 8'h3C);
    q_hit.push_back(1'b1); q_rd.push_back(8'h3C);
    issue(1'b1, 1'b0, 12'h123, 8'h00);
    tick();

    // conflict load evicts dirty 0x123, then fetches 0x223
    q_hit.push_back(1'b0);
    q_mem.push_back('{we: 1'b1, addr: 12'h123, wdata: 8'h3C});
    q_mem.push_back('{we: 1'b0, addr: 12'h223, wdata: 8'h00});
    q_gnt.push_back('{load: 1'b1, data: 8'h77});
    issue(1'b1, 1'b0, 12'h223, 8'h00);
    mem_respond(1, 8'h00);
    mem_respond(2, 8'h77);
    tick();

    // store miss to empty line: no memory traffic, gnt next cycle
    q_hit.push_back(1'b0);
    q_gnt.push_back('{load: 1'b0, data: 8'h00});
    issue(1'b0, 1'b1, 12'h456, 8'h11);
    tick();
    q_hit.push_back(1'b1); q_rd.push_back(8'h11);
    issue(1'b1, 1'b0, 12'h456, 8'h00);
    tick();

    // request while busy is dropped; reset mid-FETCH abandons the miss
    q_hit.push_back(1'b0);
    q_mem.push_back('{we: 1'b0, addr: 12'h345, wdata: 8'h00});
    issue(1'b1, 1'b0, 12'h345, 8'h00);
    q_hit.push_back(1'b0); n_err_exp++;
    issue(1'b1, 1'b0, 12'h123, 8'h00);
    tick();
    rst = 1'b1;
    tick();
    chk("rstmid_mem_req", bus.mem_req, 1'b0);
    chk("rstmid_gnt", bus.gnt, 1'b0);
    chk("rstmid_rdata", bus.rdata, 8'h00);
    rst = 1'b0;
    tick();

    // valid bits cleared: previously cached 0x123 misses again
    q_hit.push_back(1'b0);
    q_mem.push_back('{we: 1'b0, addr: 12'h123, wdata: 8'h00});
    q_gnt.push_back('{load: 1'b1, data: 8'h5A});
    issue(1'b1, 1'b0, 12'h123, 8'h00);
    mem_respond(1, 8'h5A);
    tick();

    // load+store together: load served, store dropped, protocol_err
    q_hit.push_back(1'b1); q_rd.push_back(8'h5A); n_err_exp++;
    issue(1'b1, 1'b1, 12'h123, 8'hFF);
    q_hit.push_back(1'b1); q_rd.push_back(8'h5A);
    issue(1'b1, 1'b0, 12'h123, 8'h00);
    repeat (3) tick();

    chk("left_hit", q_hit.size(), 0);
    chk("left_rd", q_rd.size(), 0);
    chk("left_mem", q_mem.size(), 0);
    chk("left_gnt", q_gnt.size(), 0);
    chk("left_err", n_err_exp, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
